// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT address generator: FSM state encoding,
// stage/bank size derivation and a width-generic bit reversal.
package fht_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  function automatic int stage_count(input int a_bit);
    return a_bit + 2;
  endfunction

  function automatic int bank_words(input int a_bit);
    return 1 << a_bit;
  endfunction

  localparam int DEF_A_BIT = 8;
  localparam int N_STAGE   = stage_count(DEF_A_BIT);
  localparam int BANK_SIZE = bank_words(DEF_A_BIT);

  // Reverses the low 'width' bits of value; the LSB ends up at bit width-1.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] res;
    logic [31:0] v;
    res = '0;
    v   = value;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        res = {res[30:0], v[0]};
        v   = v >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fht_addr_delay.sv
// Hold-able PIPE_LAT-deep delay line carrying the four bank read addresses
// and their valid tag from the read side to the write side.
module fht_addr_delay
  import fht_pkg::*;
#(
  parameter int A_BIT    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic [3:0][A_BIT-1:0] in_addr,
  output logic                  out_valid,
  output logic [3:0][A_BIT-1:0] out_addr
);

  logic [PIPE_LAT-1:0]   valid_sr;
  logic [3:0][A_BIT-1:0] addr_sr [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        addr_sr[i] <= '0;
      end
    end else if (!hold) begin
      valid_sr[0] <= in_valid;
      addr_sr[0]  <= in_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        addr_sr[i]  <= addr_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[PIPE_LAT-1];
  assign out_addr  = addr_sr[PIPE_LAT-1];

endmodule

// File: rtl/fht_addr_gen.sv
// FHT stage sequencer: per-bank read/write addresses, twiddle address and
// ping-pong write enables. Optional FHT_PERF_CNT_EN adds the oCYCLES counter.
module fht_addr_gen
  import fht_pkg::*;
#(
  parameter int A_BIT    = 8,
  parameter int PIPE_LAT = 4,
  parameter int STG_BIT  = $clog2(A_BIT + 2)
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iHOLD,
  output logic [STG_BIT-1:0] oSTAGE,
  output logic               oST_ZERO,
  output logic               oST_LAST,
  output logic [A_BIT-1:0]   oADDR_RD_0,
  output logic [A_BIT-1:0]   oADDR_RD_1,
  output logic [A_BIT-1:0]   oADDR_RD_2,
  output logic [A_BIT-1:0]   oADDR_RD_3,
  output logic [A_BIT-1:0]   oADDR_WR_0,
  output logic [A_BIT-1:0]   oADDR_WR_1,
  output logic [A_BIT-1:0]   oADDR_WR_2,
  output logic [A_BIT-1:0]   oADDR_WR_3,
  output logic [A_BIT-1:0]   oADDR_COEF,
  output logic               oWE_A,
  output logic               oWE_B,
  output logic               oSOURCE_DATA,
  output logic               oRDY,
  output logic               oDONE
`ifdef FHT_PERF_CNT_EN
  ,
  output logic [31:0]        oCYCLES
`endif
);

  localparam int NUM_STAGES = stage_count(A_BIT);
  localparam int BANK_DEPTH = bank_words(A_BIT);
  localparam logic [A_BIT-1:0]   T_LAST = A_BIT'(BANK_DEPTH - 1);
  localparam logic [STG_BIT-1:0] S_LAST = STG_BIT'(NUM_STAGES - 1);
  localparam logic [3:0]         D_LAST = 4'(PIPE_LAT - 1);
  localparam logic [3:0]         D_PEN  = (PIPE_LAT > 1) ? 4'(PIPE_LAT - 2) : 4'd0;

  fsm_t                  state, state_nxt;
  logic [A_BIT-1:0]      t, t_nxt;
  logic [STG_BIT-1:0]    s, s_nxt;
  logic [3:0]            d, d_nxt;
  logic                  busy, held;

  logic [A_BIT:0]        span, span_m1;
  logic [A_BIT-1:0]      mask, r, base, mirror, coef_nxt;
  logic [STG_BIT:0]      shamt;
  logic [3:0][A_BIT-1:0] rd_nxt, rd, wr;
  logic [A_BIT-1:0]      coef;
  logic                  rd_valid, wr_valid;

  assign busy = (state != IDLE);
  assign held = iHOLD && ((state == READ) || (state == DRAIN));

  // The DONE cycle doubles as the last drain slot of the final stage, so the
  // last write lands while oDONE is high and busy time stays stages*(depth+lat).
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    s_nxt     = s;
    d_nxt     = d;
    case (state)
      IDLE: begin
        if (iSTART) begin
          state_nxt = READ;
          t_nxt     = '0;
          s_nxt     = '0;
          d_nxt     = '0;
        end
      end
      READ: begin
        if (!held) begin
          if (t == T_LAST) begin
            t_nxt     = '0;
            d_nxt     = '0;
            state_nxt = ((s == S_LAST) && (PIPE_LAT == 1)) ? DONE : DRAIN;
          end else begin
            t_nxt = t + A_BIT'(1);
          end
        end
      end
      DRAIN: begin
        if (!held) begin
          if ((s == S_LAST) && (d == D_PEN)) begin
            state_nxt = DONE;
          end else if (d == D_LAST) begin
            state_nxt = READ;
            s_nxt     = s + STG_BIT'(1);
            t_nxt     = '0;
          end else begin
            d_nxt = d + 4'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        s_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= IDLE;
      t     <= '0;
      s     <= '0;
      d     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      s     <= s_nxt;
      d     <= d_nxt;
    end
  end

  // Addresses are computed from the next (s,t) so the registered value is
  // valid during the READ cycle that owns it.
  always_comb begin
    span     = '0;
    span_m1  = '0;
    mask     = '0;
    r        = '0;
    base     = '0;
    mirror   = '0;
    coef_nxt = '0;
    shamt    = '0;
    rd_nxt   = '0;
    if (s_nxt == '0) begin
      for (int k = 0; k < 4; k++) begin
        rd_nxt[k] = A_BIT'(bitrev(32'(t_nxt), A_BIT));
      end
    end else begin
      span      = (A_BIT+1)'(1) << (s_nxt - STG_BIT'(1));
      span_m1   = span - (A_BIT+1)'(1);
      mask      = span_m1[A_BIT-1:0];
      r         = t_nxt & mask;
      base      = t_nxt & ~mask;
      mirror    = (span[A_BIT-1:0] - r) & mask;
      rd_nxt[0] = t_nxt;
      rd_nxt[1] = t_nxt;
      rd_nxt[2] = base | mirror;
      rd_nxt[3] = base | mirror;
      if (s_nxt > STG_BIT'(1)) begin
        shamt    = (STG_BIT+1)'(A_BIT + 1) - {1'b0, s_nxt};
        coef_nxt = r << shamt;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd       <= '0;
      coef     <= '0;
      rd_valid <= 1'b0;
    end else if (!held) begin
      rd_valid <= (state_nxt == READ);
      if (state_nxt == READ) begin
        rd   <= rd_nxt;
        coef <= coef_nxt;
      end
    end
  end

  fht_addr_delay #(
    .A_BIT    (A_BIT),
    .PIPE_LAT (PIPE_LAT)
  ) u_delay (
    .clk       (iCLK),
    .rst_n     (iRESET),
    .hold      (held),
    .in_valid  (rd_valid),
    .in_addr   (rd),
    .out_valid (wr_valid),
    .out_addr  (wr)
  );

  assign oSTAGE       = s;
  assign oST_ZERO     = busy && (s == '0);
  assign oST_LAST     = busy && (s == S_LAST);
  assign oADDR_RD_0   = rd[0];
  assign oADDR_RD_1   = rd[1];
  assign oADDR_RD_2   = rd[2];
  assign oADDR_RD_3   = rd[3];
  assign oADDR_WR_0   = wr[0];
  assign oADDR_WR_1   = wr[1];
  assign oADDR_WR_2   = wr[2];
  assign oADDR_WR_3   = wr[3];
  assign oADDR_COEF   = coef;
  assign oWE_A        = wr_valid && !held && s[0];
  assign oWE_B        = wr_valid && !held && !s[0];
  assign oSOURCE_DATA = ~s[0];
  assign oRDY         = (state == IDLE);
  assign oDONE        = (state == DONE);

`ifdef FHT_PERF_CNT_EN
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oCYCLES <= '0;
    end else if ((state == IDLE) && iSTART) begin
      oCYCLES <= '0;
    end else if (busy && (oCYCLES != '1)) begin
      oCYCLES <= oCYCLES + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fht_addr_gen.md
Name: fht_addr_gen

Overview:
Parametrised successor of the FHT control unit. It sequences all stages of an N-point radix-2 FHT held in two ping-pong sets (A/B) of 4 banks, each bank 2^A_BIT words deep. Each stage it generates per-bank read/write addresses, the twiddle-coefficient address, bank-set write enables and the source select. Compared with the previous generation it adds a configurable read-to-write pipeline latency, a stall input, a done pulse and a live stage index. It sits between the top-level FHT wrapper and the butterfly datapath and memories.

Parameters:
A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT; N = 4*BANK_SIZE.
PIPE_LAT, 4, datapath latency in cycles from read address to write address, 1..15.
STG_BIT, $clog2(A_BIT+2), width of the stage index.

Ports:
iCLK  in  1  clock.
iRESET  in  1  asynchronous reset, active-low.
iSTART  in  1  start request, sampled only while oRDY=1.
iHOLD  in  1  stall; freezes the block while busy.
oSTAGE  out  STG_BIT  current stage s, 0..N_STAGE-1.
oST_ZERO  out  1  s==0 and busy.
oST_LAST  out  1  s==N_STAGE-1 and busy.
oADDR_RD_0..3  out  A_BIT each  per-bank read address.
oADDR_WR_0..3  out  A_BIT each  per-bank write address.
oADDR_COEF  out  A_BIT  twiddle ROM address.
oWE_A, oWE_B  out  1 each  write enables for bank sets A and B.
oSOURCE_DATA  out  1  1 = datapath reads set A, 0 = reads set B.
oRDY  out  1  idle/ready.
oDONE  out  1  one-cycle pulse at completion.

Behaviour:
- N_STAGE = A_BIT+2. Each stage has BANK_SIZE READ cycles (t = 0..BANK_SIZE-1), then PIPE_LAT DRAIN cycles. Stage length is BANK_SIZE+PIPE_LAT; total busy time is N_STAGE*(BANK_SIZE+PIPE_LAT) non-held cycles.
- FSM states:
  - IDLE -> READ when iSTART=1 at a clock edge. oRDY drops on the next cycle, with t=0 and s=0.
  - READ -> DRAIN after t=BANK_SIZE-1.
  - DRAIN -> READ (s+1, t=0) after PIPE_LAT cycles if s<N_STAGE-1.
  - DRAIN -> DONE otherwise.
  - DONE -> IDLE after 1 cycle. oDONE=1 only in DONE; oRDY=1 only in IDLE.
- Read addresses (registered; valid in READ cycles):
  - s=0: all four banks = bitrev_A_BIT(t).
  - s>=1: define S = 2^(s-1), r = t mod S, base = t-r.
    - Banks 0,1 = t.
    - Banks 2,3 = base + ((S-r) mod S).
  - oADDR_COEF = 0 for s<=1; otherwise r*(BANK_SIZE/S).
- Writes:
  - oADDR_WR_k is oADDR_RD_k delayed PIPE_LAT non-held cycles through a valid-tagged delay line.
  - The write enable is asserted when the delayed valid bit is 1: oWE_B for even s, oWE_A for odd s. Never both at once.
  - oSOURCE_DATA = 1 for even s, 0 for odd s.
  - The final result lands in set A if N_STAGE is even, else in set B.
- Stall: iHOLD=1 while busy freezes the FSM, t, s and the delay line. Addresses hold their values and oWE_A/oWE_B are forced to 0. iHOLD is ignored in IDLE/DONE.
- iSTART while busy or in DONE is ignored. There is no restart mid-transform.
- Reset values: state IDLE, s=0, t=0, delay line cleared, all addresses 0, WE 0, oSOURCE_DATA 1, oRDY 1, oDONE 0. Reset mid-transform aborts immediately to these values.
- Wrap-around: t wraps only through the READ->DRAIN transition. The s counter never exceeds N_STAGE-1.

Optional Feature:
FHT_PERF_CNT_EN:
- Defined: adds output oCYCLES [31:0], counting every busy cycle including held cycles. It clears on the accepted start, holds its value in IDLE and saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fht_pkg holds:
  - typedef fsm_t {IDLE, READ, DRAIN, DONE}
  - function bitrev(width-generic)
  - localparams N_STAGE and BANK_SIZE derivation
- One sub-module, fht_addr_delay: a PIPE_LAT-deep, hold-able delay line for 4 addresses plus the valid bit.

Test Plan:
- A_BIT=3, PIPE_LAT=2, start pulse -> oRDY low for exactly 50 cycles, oDONE pulses once, then oRDY=1. Stages step 0..4.
- Same configuration, s=0, t=3 -> all oADDR_RD = 6. The same value appears on oADDR_WR 2 cycles later with oWE_B=1 and oWE_A=0.
- s=3, t=5 -> RD_0/1 = 5, RD_2/3 = 7, COEF = 2. s=2, t=4 -> RD_2/3 = 4, COEF = 0.
- Assert iHOLD for 7 cycles mid-stage 2 -> addresses frozen, WE 0, total busy = 57 cycles, address sequence matches golden model.
- iSTART pulsed at cycle 10 of busy, and reset asserted at cycle 30 -> the start is ignored. Reset returns all outputs to reset values asynchronously, and a fresh start then completes normally.
- With FHT_PERF_CNT_EN and 7 held cycles -> oCYCLES = 57 after done and unchanged in IDLE.
